// File: rtl/paddle_button_conditioner.sv
// paddle_button_conditioner
// Conditions the four raw active-low KEY inputs for the paddle-movement stage.
// Per button: 2-FF synchroniser, counter debounce, opposing-pair cancel and
// rate-limited one-clock active-low move strobes on a free-running period.
// Bit mapping: [0] down, [1] up, [2] left, [3] right.
// Optional feature: define PADDLE_COND_ACCEL_EN to double the strobe rate
// (extra half-period strobe) once a button has been held for ACCEL_TICKS ticks.
module paddle_button_conditioner #(
  parameter int DEBOUNCE_CYCLES    = 500000,
  parameter int MOVE_PERIOD_CYCLES = 833333,
  parameter int ACCEL_TICKS        = 30
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] keyIn,
  input  logic       enable,
  output logic [3:0] buttonOut,
  output logic [3:0] heldOut,
  output logic [3:0] pressEvent
);

  localparam int DBW = $clog2(DEBOUNCE_CYCLES);
  localparam int MPW = $clog2(MOVE_PERIOD_CYCLES);
  localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE_CYCLES - 1);
  localparam logic [MPW-1:0] MP_LAST = MPW'(MOVE_PERIOD_CYCLES - 1);

  // Parameter sanity: counters below two clocks would make the compare logic degenerate.
  if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
    $error("DEBOUNCE_CYCLES must be at least 2");
  end
  if (MOVE_PERIOD_CYCLES < 2) begin : g_bad_period
    $error("MOVE_PERIOD_CYCLES must be at least 2");
  end
  if (ACCEL_TICKS < 1) begin : g_bad_accel
    $error("ACCEL_TICKS must be at least 1");
  end

  logic [3:0]     sync1_q, sync1_d;
  logic [3:0]     sync2_q, sync2_d;
  logic [3:0]     held_q, held_d;
  logic [3:0]     held_prev_q, held_prev_d;
  logic [3:0]     press_q, press_d;
  logic [3:0]     button_q, button_d;
  logic [MPW-1:0] move_cnt_q, move_cnt_d;
  logic           tick;
  logic [3:0]     eff_held;
  logic [3:0]     fire;

  assign tick = (move_cnt_q == MP_LAST);

  // Per-bit debounce: the stable level only follows the synchronised level
  // after DEBOUNCE_CYCLES consecutive disagreeing samples.
  for (genvar gi = 0; gi < 4; gi++) begin : g_debounce
    logic [DBW-1:0] db_cnt_q, db_cnt_d;
    logic           held_bit_d;

    // Next debounce count and stable level for this button.
    always_comb begin
      db_cnt_d   = db_cnt_q;
      held_bit_d = held_q[gi];
      if ((~sync2_q[gi]) == held_q[gi]) begin
        db_cnt_d = '0;
      end else if (db_cnt_q == DB_LAST) begin
        held_bit_d = ~sync2_q[gi];
        db_cnt_d   = '0;
      end else begin
        db_cnt_d = db_cnt_q + DBW'(1);
      end
    end

    // Debounce counter register.
    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        db_cnt_q <= '0;
      end else begin
        db_cnt_q <= db_cnt_d;
      end
    end

    assign held_d[gi] = held_bit_d;
  end

  // Up and down (or left and right) together cancel each other for movement only;
  // heldOut still reports the raw debounced level.
  always_comb begin
    eff_held = held_q;
    if (held_q[0] && held_q[1]) begin
      eff_held[1:0] = 2'b00;
    end
    if (held_q[2] && held_q[3]) begin
      eff_held[3:2] = 2'b00;
    end
  end

`ifdef PADDLE_COND_ACCEL_EN
  localparam int HW = $clog2(ACCEL_TICKS + 1);
  localparam logic [HW-1:0]  HOLD_SAT = HW'(ACCEL_TICKS);
  localparam logic [MPW-1:0] MP_HALF  = MPW'(MOVE_PERIOD_CYCLES / 2 - 1);

  logic       half_tick;
  logic [3:0] fast;

  assign half_tick = (move_cnt_q == MP_HALF);

  // Per-bit hold counters: count ticks of uninterrupted effective hold.
  for (genvar gi = 0; gi < 4; gi++) begin : g_accel
    logic [HW-1:0] hold_cnt_q, hold_cnt_d;

    // Clear on release, cancel or pause; saturate at HOLD_SAT.
    always_comb begin
      hold_cnt_d = hold_cnt_q;
      if (!eff_held[gi] || !enable) begin
        hold_cnt_d = '0;
      end else if (tick && (hold_cnt_q != HOLD_SAT)) begin
        hold_cnt_d = hold_cnt_q + HW'(1);
      end
    end

    // Hold counter register.
    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        hold_cnt_q <= '0;
      end else begin
        hold_cnt_q <= hold_cnt_d;
      end
    end

    assign fast[gi] = (hold_cnt_q == HOLD_SAT);
  end

  // Strobe on every tick, plus at the half-period once acceleration is engaged.
  always_comb begin
    fire = eff_held & {4{enable}} & ({4{tick}} | ({4{half_tick}} & fast));
  end
`else
  // Strobe once per period for each effectively held button.
  always_comb begin
    fire = eff_held & {4{enable & tick}};
  end
`endif

  // Next-state for synchroniser, press detection, period counter and strobes.
  always_comb begin
    sync1_d     = keyIn;
    sync2_d     = sync1_q;
    held_prev_d = held_q;
    press_d     = held_q & ~held_prev_q;
    move_cnt_d  = tick ? '0 : (move_cnt_q + MPW'(1));
    button_d    = ~fire;
  end

  // Shared state registers; reset values give released, idle outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1_q     <= 4'b1111;
      sync2_q     <= 4'b1111;
      held_q      <= 4'b0000;
      held_prev_q <= 4'b0000;
      press_q     <= 4'b0000;
      button_q    <= 4'b1111;
      move_cnt_q  <= '0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      held_q      <= held_d;
      held_prev_q <= held_prev_d;
      press_q     <= press_d;
      button_q    <= button_d;
      move_cnt_q  <= move_cnt_d;
    end
  end

  assign buttonOut  = button_q;
  assign heldOut    = held_q;
  assign pressEvent = press_q;

endmodule
